// File: rtl/fourbit_encoder_reg.sv
// Registered 16-to-4 one-hot encoder with malformed-word detection and
// sticky/saturating error tracking, recovering timing codes from T0..T15.
module fourbit_encoder_reg #(
    parameter int CNT_W     = 8,
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      times,
    input  logic             err_clr,
    output logic             out_valid,
    output logic [3:0]       code,
    output logic             onehot_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    // Handshake: valid-only, no ready. Each cycle with in_valid=1 yields exactly
    // one beat with out_valid=1 on the following cycle; the sink must accept it.

    logic [15:0]      times_m;
    logic [3:0]       hi_idx;
    logic [3:0]       lo_idx;
    logic             found;
    logic             multi;
    logic             bad_word;

    logic             out_valid_q, out_valid_d;
    logic [3:0]       code_q, code_d;
    logic             onehot_err_q, onehot_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Masking keeps X/Z on an idle bus from reaching any register input.
    assign times_m = in_valid ? times : 16'h0000;

    always_comb begin
        hi_idx = 4'd0;
        lo_idx = 4'd0;
        found  = 1'b0;
        multi  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (times_m[i]) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    lo_idx = 4'(i);
                end
                hi_idx = 4'(i);
                found  = 1'b1;
            end
        end
    end

    assign bad_word = !found || multi;

    always_comb begin
        out_valid_d  = in_valid;
        code_d       = code_q;
        onehot_err_d = onehot_err_q;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        if (in_valid) begin
            code_d       = PRIO_HIGH ? hi_idx : lo_idx;
            onehot_err_d = bad_word;
        end
        // A clear in the same cycle as a new error wins; that error goes uncounted.
        if (err_clr) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end else if (in_valid && bad_word) begin
            err_sticky_d = 1'b1;
            if (err_count_q != {CNT_W{1'b1}}) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            code_q       <= 4'd0;
            onehot_err_q <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            code_q       <= code_d;
            onehot_err_q <= onehot_err_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign code       = code_q;
    assign onehot_err = onehot_err_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_fourbit_encoder_reg.sv
// Directed bench for fourbit_encoder_reg: a high-priority and a low-priority
// instance share one stimulus stream; outputs are packed and compared per step.
module tb_fourbit_encoder_reg;

    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] times = 16'h0000;
    logic        err_clr = 1'b0;

    logic             hi_out_valid, lo_out_valid;
    logic [3:0]       hi_code, lo_code;
    logic             hi_onehot_err, lo_onehot_err;
    logic             hi_err_sticky, lo_err_sticky;
    logic [CNT_W-1:0] hi_err_count, lo_err_count;

    // {out_valid, code, onehot_err, err_sticky, err_count}
    logic [14:0] obs_hi, obs_lo, exp_hi, exp_lo;

    int n_cmp = 0;
    int n_bad = 0;

    fourbit_encoder_reg #(.CNT_W(CNT_W), .PRIO_HIGH(1'b1)) u_hi (
        .clk(clk), .rst(rst), .in_valid(in_valid), .times(times), .err_clr(err_clr),
        .out_valid(hi_out_valid), .code(hi_code), .onehot_err(hi_onehot_err),
        .err_sticky(hi_err_sticky), .err_count(hi_err_count)
    );

    fourbit_encoder_reg #(.CNT_W(CNT_W), .PRIO_HIGH(1'b0)) u_lo (
        .clk(clk), .rst(rst), .in_valid(in_valid), .times(times), .err_clr(err_clr),
        .out_valid(lo_out_valid), .code(lo_code), .onehot_err(lo_onehot_err),
        .err_sticky(lo_err_sticky), .err_count(lo_err_count)
    );

    assign obs_hi = {hi_out_valid, hi_code, hi_onehot_err, hi_err_sticky, hi_err_count};
    assign obs_lo = {lo_out_valid, lo_code, lo_onehot_err, lo_err_sticky, lo_err_count};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        times = 16'h0000;
        err_clr = 1'b0;
        step();
        step();
        exp_hi = 15'h0000;
        n_cmp++;
        if (obs_hi !== exp_hi) begin
            n_bad++;
            $display("FAIL reset_hi: got %h expected %h", obs_hi, exp_hi);
        end
        n_cmp++;
        if (obs_lo !== exp_hi) begin
            n_bad++;
            $display("FAIL reset_lo: got %h expected %h", obs_lo, exp_hi);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_sweep();
        for (int k = 15; k >= 0; k--) begin
            in_valid = 1'b1;
            times = 16'(1) << k;
            step();
            exp_hi = {1'b1, 4'(k), 1'b0, 1'b0, 8'd0};
            n_cmp++;
            if (obs_hi !== exp_hi) begin
                n_bad++;
                $display("FAIL sweep_hi k=%0d: got %h expected %h", k, obs_hi, exp_hi);
            end
            n_cmp++;
            if (obs_lo !== exp_hi) begin
                n_bad++;
                $display("FAIL sweep_lo k=%0d: got %h expected %h", k, obs_lo, exp_hi);
            end
        end
    endtask

    task automatic test_zero_word();
        in_valid = 1'b1;
        times = 16'h0000;
        step();
        exp_hi = {1'b1, 4'd0, 1'b1, 1'b1, 8'd1};
        n_cmp++;
        if (obs_hi !== exp_hi) begin
            n_bad++;
            $display("FAIL zero_hi: got %h expected %h", obs_hi, exp_hi);
        end
        n_cmp++;
        if (obs_lo !== exp_hi) begin
            n_bad++;
            $display("FAIL zero_lo: got %h expected %h", obs_lo, exp_hi);
        end
    endtask

    task automatic test_multi_hot();
        in_valid = 1'b1;
        times = 16'h8001;
        step();
        exp_hi = {1'b1, 4'd15, 1'b1, 1'b1, 8'd2};
        exp_lo = {1'b1, 4'd0, 1'b1, 1'b1, 8'd2};
        n_cmp++;
        if (obs_hi !== exp_hi) begin
            n_bad++;
            $display("FAIL multi_hi: got %h expected %h", obs_hi, exp_hi);
        end
        n_cmp++;
        if (obs_lo !== exp_lo) begin
            n_bad++;
            $display("FAIL multi_lo: got %h expected %h", obs_lo, exp_lo);
        end
    endtask

    task automatic test_idle_hold();
        in_valid = 1'b0;
        times = 16'hxxxx;
        step();
        exp_hi = {1'b0, 4'd15, 1'b1, 1'b1, 8'd2};
        exp_lo = {1'b0, 4'd0, 1'b1, 1'b1, 8'd2};
        n_cmp++;
        if (obs_hi !== exp_hi) begin
            n_bad++;
            $display("FAIL idle_hold_hi: got %h expected %h", obs_hi, exp_hi);
        end
        n_cmp++;
        if (obs_lo !== exp_lo) begin
            n_bad++;
            $display("FAIL idle_hold_lo: got %h expected %h", obs_lo, exp_lo);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_hi = {1'b0, 4'd15, 1'b1, 1'b0, 8'd0};
        n_cmp++;
        if (obs_hi !== exp_hi) begin
            n_bad++;
            $display("FAIL clr_idle_hi: got %h expected %h", obs_hi, exp_hi);
        end
        times = 16'h0000;
    endtask

    task automatic test_saturation();
        logic [7:0] exp_cnt;
        in_valid = 1'b1;
        times = 16'h0003;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
                exp_cnt = (i > 255) ? 8'd255 : 8'(i);
                exp_hi = {1'b1, 4'd1, 1'b1, 1'b1, exp_cnt};
                exp_lo = {1'b1, 4'd0, 1'b1, 1'b1, exp_cnt};
                n_cmp++;
                if (obs_hi !== exp_hi) begin
                    n_bad++;
                    $display("FAIL sat_hi i=%0d: got %h expected %h", i, obs_hi, exp_hi);
                end
                n_cmp++;
                if (obs_lo !== exp_lo) begin
                    n_bad++;
                    $display("FAIL sat_lo i=%0d: got %h expected %h", i, obs_lo, exp_lo);
                end
            end
        end
    endtask

    task automatic test_clr_with_error();
        in_valid = 1'b1;
        times = 16'h0000;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_hi = {1'b1, 4'd0, 1'b1, 1'b0, 8'd0};
        n_cmp++;
        if (obs_hi !== exp_hi) begin
            n_bad++;
            $display("FAIL clr_with_err: got %h expected %h", obs_hi, exp_hi);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        times = 16'h0101;
        step();
        exp_hi = {1'b1, 4'd8, 1'b1, 1'b1, 8'd1};
        n_cmp++;
        if (obs_hi !== exp_hi) begin
            n_bad++;
            $display("FAIL pre_reset: got %h expected %h", obs_hi, exp_hi);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        exp_hi = 15'h0000;
        n_cmp++;
        if (obs_hi !== exp_hi) begin
            n_bad++;
            $display("FAIL async_reset_hi: got %h expected %h", obs_hi, exp_hi);
        end
        n_cmp++;
        if (obs_lo !== exp_hi) begin
            n_bad++;
            $display("FAIL async_reset_lo: got %h expected %h", obs_lo, exp_hi);
        end
        #2;
        rst = 1'b0;
        in_valid = 1'b1;
        times = 16'h0040;
        step();
        exp_hi = {1'b1, 4'd6, 1'b0, 1'b0, 8'd0};
        n_cmp++;
        if (obs_hi !== exp_hi) begin
            n_bad++;
            $display("FAIL post_reset: got %h expected %h", obs_hi, exp_hi);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] c;
        for (int n = 0; n < 30; n++) begin
            c = 4'($urandom_range(15, 0));
            in_valid = 1'b1;
            times = 16'(1) << c;
            step();
            exp_hi = {1'b1, c, 1'b0, 1'b0, 8'd0};
            n_cmp++;
            if (obs_hi !== exp_hi) begin
                n_bad++;
                $display("FAIL loopback_hi n=%0d: got %h expected %h", n, obs_hi, exp_hi);
            end
            n_cmp++;
            if (obs_lo !== exp_hi) begin
                n_bad++;
                $display("FAIL loopback_lo n=%0d: got %h expected %h", n, obs_lo, exp_hi);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_zero_word();
        test_multi_hot();
        test_idle_hold();
        test_saturation();
        test_clr_with_error();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
